// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch run/pause/clear controller with ASCII HH:MM:SS:CC outputs
module stopwatch_ctrl #(
    parameter int TICK_DIV = 10000,
    parameter int DIV_W    = 14
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    output logic       run,
    output logic       tick,
    output logic [7:0] cnt_1,
    output logic [7:0] cnt_10,
    output logic [7:0] sec_1,
    output logic [7:0] sec_10,
    output logic [7:0] min_1,
    output logic [7:0] min_10,
    output logic [7:0] hour_1,
    output logic [7:0] hour_10
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

    localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

    state_t           state, state_next;
    logic [2:0]       ss_sync, clr_sync;
    logic             ev_ss, ev_clr;
    logic [DIV_W-1:0] presc;
    logic [31:0]      bcd, bcd_inc;
    logic             carry;

    // [0],[1] synchronize; [2] holds the previous synchronized sample for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ss_sync  <= '0;
            clr_sync <= '0;
        end else begin
            ss_sync  <= {ss_sync[1:0], btn_start_stop};
            clr_sync <= {clr_sync[1:0], btn_clear};
        end
    end

    assign ev_ss  = ss_sync[1] & ~ss_sync[2];
    assign ev_clr = clr_sync[1] & ~clr_sync[2];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ev_ss) state_next = RUN;
            RUN:     if (ev_ss) state_next = PAUSE;
            PAUSE: begin
                if (ev_clr)     state_next = IDLE;
                else if (ev_ss) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            run   <= 1'b0;
        end else begin
            state <= state_next;
            run   <= (state_next == RUN);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= (state == RUN) && (presc == LAST);
            if (state_next == IDLE)
                presc <= '0;
            else if (state == RUN)
                presc <= (presc == LAST) ? '0 : presc + 1'b1;
        end
    end

    // Nibbles from LSB: cc1, cc10, ss1, ss10, mm1, mm10, hh1, hh10; full ripple in one cycle
    always_comb begin
        bcd_inc = bcd;
        carry   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (bcd[4*i +: 4] == ((i == 3 || i == 5) ? 4'd5 : 4'd9)) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        if (carry) begin
            if (bcd[31:24] == 8'h23) begin
                bcd_inc[31:24] = 8'h00;
            end else if (bcd[27:24] == 4'd9) begin
                bcd_inc[27:24] = 4'd0;
                bcd_inc[31:28] = bcd[31:28] + 4'd1;
            end else begin
                bcd_inc[27:24] = bcd[27:24] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            bcd <= '0;
        else if (state_next == IDLE)
            bcd <= '0;
        else if (tick)
            bcd <= bcd_inc;
    end

    assign cnt_1   = {4'h3, bcd[3:0]};
    assign cnt_10  = {4'h3, bcd[7:4]};
    assign sec_1   = {4'h3, bcd[11:8]};
    assign sec_10  = {4'h3, bcd[15:12]};
    assign min_1   = {4'h3, bcd[19:16]};
    assign min_10  = {4'h3, bcd[23:20]};
    assign hour_1  = {4'h3, bcd[27:24]};
    assign hour_10 = {4'h3, bcd[31:28]};
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl against an elapsed-time model
module tb_stopwatch_ctrl;
    localparam int TICK_DIV = 4;
    localparam int DAY      = 8640000;
    localparam int PRE      = 23*360000 + 59*6000 + 59*100 + 98;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;
    localparam logic [63:0] ZEROS = 64'h3030303030303030;

    logic clk = 1'b0;
    logic rst, btn_start_stop, btn_clear;
    logic run, tick;
    logic [7:0] cnt_1, cnt_10, sec_1, sec_10, min_1, min_10, hour_1, hour_10;
    logic [63:0] dig;

    int checks = 0;
    int failures = 0;
    logic cmp_en, preload_en;

    int m_mode, m_time, m_phase;
    logic m_tick;
    logic [2:0] hs, hc;

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DIV_W(2)) dut (
        .clk(clk), .rst(rst), .btn_start_stop(btn_start_stop), .btn_clear(btn_clear),
        .run(run), .tick(tick),
        .cnt_1(cnt_1), .cnt_10(cnt_10), .sec_1(sec_1), .sec_10(sec_10),
        .min_1(min_1), .min_10(min_10), .hour_1(hour_1), .hour_10(hour_10)
    );

    always #5 clk = ~clk;

    assign dig = {hour_10, hour_1, min_10, min_1, sec_10, sec_1, cnt_10, cnt_1};

    function automatic logic [63:0] exp_digits(input int t);
        int hh, mm, ss, cc;
        hh = t / 360000;
        mm = (t / 6000) % 60;
        ss = (t / 100) % 60;
        cc = t % 100;
        return {8'(48 + hh/10), 8'(48 + hh%10), 8'(48 + mm/10), 8'(48 + mm%10),
                8'(48 + ss/10), 8'(48 + ss%10), 8'(48 + cc/10), 8'(48 + cc%10)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: elapsed hundredths as a plain integer, button events from sampled history
    always @(posedge clk or negedge rst) begin : model
        int t, ph, md;
        logic tk, es, ec;
        if (!rst) begin
            m_mode <= M_IDLE; m_time <= 0; m_phase <= 0; m_tick <= 1'b0;
            hs <= '0; hc <= '0;
        end else begin
            es = hs[1] & ~hs[2];
            ec = hc[1] & ~hc[2];
            t  = preload_en ? PRE : m_time;
            if (m_tick) t = (t + 1) % DAY;
            ph = m_phase;
            tk = 1'b0;
            if (m_mode == M_RUN) begin
                if (ph == TICK_DIV - 1) begin ph = 0; tk = 1'b1; end
                else ph = ph + 1;
            end
            md = m_mode;
            case (m_mode)
                M_IDLE:  if (es) md = M_RUN;
                M_RUN:   if (es) md = M_PAUSE;
                default: if (ec) md = M_IDLE; else if (es) md = M_RUN;
            endcase
            if (md == M_IDLE) begin t = 0; ph = 0; end
            m_mode <= md; m_time <= t; m_phase <= ph; m_tick <= tk;
            hs <= {hs[1:0], btn_start_stop};
            hc <= {hc[1:0], btn_clear};
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("run", 64'(run), 64'(m_mode == M_RUN));
            check("tick", 64'(tick), 64'(m_tick));
            check("digits", dig, exp_digits(m_time));
        end
    end

    task automatic wait_ticks(input int n, input int bound);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (tick) seen++;
        end
        checks++;
        if (seen < n) begin
            failures++;
            $display("FAIL wait_ticks: got %0d ticks expected %0d", seen, n);
        end
    endtask

    task automatic pulse(input logic s, input logic c);
        @(negedge clk);
        btn_start_stop = s;
        btn_clear = c;
        @(negedge clk);
        btn_start_stop = 1'b0;
        btn_clear = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m, p;
        rst = 1'b0; btn_start_stop = 1'b0; btn_clear = 1'b0;
        cmp_en = 1'b0; preload_en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_digits", dig, ZEROS);
        check("reset_run", 64'(run), 64'd0);
        check("reset_tick", 64'(tick), 64'd0);
        rst = 1'b1;
        cmp_en = 1'b1;

        n = 0;
        repeat (50) begin @(negedge clk); if (tick) n++; end
        check("idle_ticks", 64'(n), 64'd0);
        check("idle_digits", dig, ZEROS);
        check("idle_run", 64'(run), 64'd0);

        pulse(1'b1, 1'b0);
        wait_ticks(1, 20);
        n = 0;
        do begin @(negedge clk); n++; end while (!tick && n < 20);
        check("tick_period", 64'(n), 64'd4);
        wait_ticks(398, 398*4 + 20);
        @(negedge clk);
        check("run_4s_digits", dig, 64'h3030303030343030);
        check("run_4s_run", 64'(run), 64'd1);

        @(negedge clk);
        btn_start_stop = 1'b1;
        repeat (20) @(negedge clk);
        btn_start_stop = 1'b0;
        repeat (4) @(negedge clk);
        check("pause_run", 64'(run), 64'd0);
        p = m_phase;
        pulse(1'b1, 1'b0);
        n = 0;
        while (!run && n < 10) begin @(negedge clk); n++; end
        m = 0;
        while (!tick && m < 10) begin @(negedge clk); m++; end
        check("resume_latency", 64'(m), 64'(4 - p));

        pulse(1'b1, 1'b0);
        repeat (6) @(negedge clk);
        #1;
        force dut.bcd = 32'h23595998;
        preload_en = 1'b1;
        @(negedge clk);
        #1;
        release dut.bcd;
        preload_en = 1'b0;
        @(negedge clk);
        check("preload_digits", dig, 64'h3233353935393938);
        pulse(1'b1, 1'b0);
        wait_ticks(1, 20);
        @(negedge clk);
        check("pre_wrap_digits", dig, 64'h3233353935393939);
        wait_ticks(1, 20);
        @(negedge clk);
        check("wrap_digits", dig, ZEROS);

        pulse(1'b0, 1'b1);
        repeat (6) @(negedge clk);
        check("clear_in_run", 64'(run), 64'd1);
        pulse(1'b1, 1'b0);
        repeat (6) @(negedge clk);
        pulse(1'b0, 1'b1);
        repeat (6) @(negedge clk);
        check("clear_in_pause_digits", dig, ZEROS);
        check("clear_in_pause_run", 64'(run), 64'd0);
        pulse(1'b1, 1'b0);
        repeat (20) @(negedge clk);
        pulse(1'b1, 1'b0);
        repeat (6) @(negedge clk);
        pulse(1'b1, 1'b1);
        repeat (6) @(negedge clk);
        check("both_in_pause_digits", dig, ZEROS);
        check("both_in_pause_run", 64'(run), 64'd0);
        pulse(1'b1, 1'b1);
        repeat (6) @(negedge clk);
        check("both_in_idle_run", 64'(run), 64'd1);

        wait_ticks(1, 20);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_digits", dig, ZEROS);
        check("async_rst_run", 64'(run), 64'd0);
        check("async_rst_tick", 64'(tick), 64'd0);
        btn_start_stop = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("held_after_rst_run", 64'(run), 64'd1);
        btn_start_stop = 1'b0;
        repeat (10) @(negedge clk);
        check("held_released_run", 64'(run), 64'd1);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 1500) begin
                #2 rst = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) btn_start_stop = ~btn_start_stop;
            if ($urandom_range(0, 29) == 0) btn_clear = ~btn_clear;
        end
        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
